// File: rtl/program_loader_unit.sv
// Boot loader: streams a length-prefixed, XOR-checksummed program into
// instruction memory and holds the core in reset until it verifies.
module program_loader_unit #(
  parameter int MEM_DEPTH = 256
) (
  input  logic       i_clock,
  input  logic       i_reset,
  input  logic       i_start,
  input  logic       i_in_valid,
  input  logic [7:0] i_in_data,
  output logic       o_in_ready,
  output logic       o_im_write_enable,
  output logic [7:0] o_im_write_address,
  output logic [7:0] o_im_write_data,
  output logic       o_cpu_reset,
  output logic       o_done,
  output logic       o_error
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN,
    S_LOAD,
    S_CHECK,
    S_RUN,
    S_ERROR
  } state_t;

  localparam logic [8:0] DEPTH = 9'(MEM_DEPTH);

  state_t     r_state;
  logic [7:0] r_len;
  logic [7:0] r_idx;
  logic [7:0] r_acc;

  logic w_xfer;
  logic w_len_bad;
  logic w_last;

  assign w_xfer    = i_in_valid && o_in_ready;
  assign w_len_bad = (i_in_data == 8'd0) || ({1'b0, i_in_data} > DEPTH);
  assign w_last    = (r_idx == r_len - 8'd1);

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_state            <= S_IDLE;
      r_len              <= 8'd0;
      r_idx              <= 8'd0;
      r_acc              <= 8'd0;
      o_in_ready         <= 1'b0;
      o_im_write_enable  <= 1'b0;
      o_im_write_address <= 8'd0;
      o_im_write_data    <= 8'd0;
      o_cpu_reset        <= 1'b1;
      o_done             <= 1'b0;
      o_error            <= 1'b0;
    end else begin
      o_im_write_enable <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          if (i_start) begin
            r_state    <= S_LEN;
            o_in_ready <= 1'b1;
          end
        end
        S_LEN: begin
          if (w_xfer) begin
            if (w_len_bad) begin
              r_state    <= S_ERROR;
              o_in_ready <= 1'b0;
              o_error    <= 1'b1;
            end else begin
              r_state <= S_LOAD;
              r_len   <= i_in_data;
              r_idx   <= 8'd0;
              r_acc   <= 8'd0;
            end
          end
        end
        S_LOAD: begin
          if (w_xfer) begin
            o_im_write_enable  <= 1'b1;
            o_im_write_address <= r_idx;
            o_im_write_data    <= i_in_data;
            r_acc              <= r_acc ^ i_in_data;
            r_idx              <= r_idx + 8'd1;
            if (w_last) r_state <= S_CHECK;
          end
        end
        S_CHECK: begin
          if (w_xfer) begin
            o_in_ready <= 1'b0;
            if (i_in_data == r_acc) begin
              r_state     <= S_RUN;
              o_done      <= 1'b1;
              o_cpu_reset <= 1'b0;
            end else begin
              r_state <= S_ERROR;
              o_error <= 1'b1;
            end
          end
        end
        S_RUN: begin
          if (i_start) begin
            r_state     <= S_LEN;
            o_in_ready  <= 1'b1;
            o_cpu_reset <= 1'b1;
            o_done      <= 1'b0;
          end
        end
        S_ERROR: begin
          if (i_start) begin
            r_state    <= S_LEN;
            o_in_ready <= 1'b1;
            o_error    <= 1'b0;
          end
        end
        default: begin
          r_state    <= S_IDLE;
          o_in_ready <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_program_loader_unit.sv
// Self-checking bench for program_loader_unit: write scoreboard plus
// per-scenario status checks.
module tb_program_loader_unit;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       start;
  logic       valid;
  logic [7:0] data;
  logic       ready;
  logic       we;
  logic [7:0] waddr;
  logic [7:0] wdata;
  logic       cpu_rst;
  logic       done;
  logic       err;

  logic       start4;
  logic       valid4;
  logic [7:0] data4;
  logic       ready4;
  logic       we4;
  logic [7:0] waddr4;
  logic [7:0] wdata4;
  logic       cpu_rst4;
  logic       done4;
  logic       err4;

  program_loader_unit #(.MEM_DEPTH(256)) dut (
    .i_clock           (clk),
    .i_reset           (rst),
    .i_start           (start),
    .i_in_valid        (valid),
    .i_in_data         (data),
    .o_in_ready        (ready),
    .o_im_write_enable (we),
    .o_im_write_address(waddr),
    .o_im_write_data   (wdata),
    .o_cpu_reset       (cpu_rst),
    .o_done            (done),
    .o_error           (err)
  );

  program_loader_unit #(.MEM_DEPTH(4)) dut4 (
    .i_clock           (clk),
    .i_reset           (rst),
    .i_start           (start4),
    .i_in_valid        (valid4),
    .i_in_data         (data4),
    .o_in_ready        (ready4),
    .o_im_write_enable (we4),
    .o_im_write_address(waddr4),
    .o_im_write_data   (wdata4),
    .o_cpu_reset       (cpu_rst4),
    .o_done            (done4),
    .o_error           (err4)
  );

  typedef struct packed {
    logic [7:0] a;
    logic [7:0] d;
  } wr_t;

  int   errors = 0;
  int   checks = 0;
  int   cyc    = 0;
  int   n_wr   = 0;
  wr_t  exp_q[$];
  int   wr_cyc[$];
  logic [7:0] prog[$];

  always @(posedge clk) cyc++;

  // Write-port scoreboard: every strobe must match the next expected write.
  always @(negedge clk) begin
    wr_t e;
    if (we) begin
      n_wr++;
      wr_cyc.push_back(cyc);
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_write got addr=%0h data=%0h want none",
                 waddr, wdata);
      end else begin
        e = exp_q.pop_front();
        if ({waddr, wdata} !== e) begin
          errors++;
          $display("FAIL write got addr=%0h data=%0h want addr=%0h data=%0h",
                   waddr, wdata, e.a, e.d);
        end
      end
    end
  end

  task automatic send(input logic [7:0] b);
    int n = 0;
    valid = 1'b1;
    data  = b;
    @(negedge clk);
    while (!ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!ready) begin
      errors++;
      checks++;
      $display("FAIL send_timeout got ready=0 want ready=1 byte=%0h", b);
      valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_start();
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    checks++;
    if ({ready, cpu_rst, done} !== 3'b110) begin
      errors++;
      $display("FAIL start got ready/cpu_rst/done=%b want 110",
               {ready, cpu_rst, done});
    end
  endtask

  // prog = {L, body..., checksum}; gap inserts idle cycles between bytes,
  // start_at raises Start during the gap after that body byte (0 = never).
  task automatic run_stream(input bit gap, input int start_at);
    int l;
    l = int'(prog[0]);
    for (int i = 0; i < l + 2; i++) begin
      if (i >= 1 && i <= l)
        exp_q.push_back({8'(i - 1), prog[i]});
      send(prog[i]);
      if (gap) begin
        valid = 1'b0;
        if (i == start_at) start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
      end
    end
    valid = 1'b0;
  endtask

  task automatic test_reset();
    rst   = 1'b1;
    start = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({ready, we, cpu_rst, done, err} !== 5'b00100 || waddr !== 8'd0) begin
      errors++;
      $display("FAIL reset got rdy/we/cpu/done/err=%b addr=%0h want 00100 0",
               {ready, we, cpu_rst, done, err}, waddr);
    end
    rst   = 1'b0;
    start = 1'b0;
    @(posedge clk);
    #1;
    checks++;
    if (ready !== 1'b0) begin
      errors++;
      $display("FAIL idle_ready got %b want 0", ready);
    end
  endtask

  task automatic test_back_to_back();
    int w0;
    int c0;
    do_start();
    prog = '{8'h03, 8'h21, 8'h42, 8'h84, 8'hE7};
    w0 = n_wr;
    c0 = wr_cyc.size();
    run_stream(1'b0, 0);
    checks++;
    if ({done, cpu_rst, ready, err} !== 4'b1000) begin
      errors++;
      $display("FAIL b2b_status got done/cpu/rdy/err=%b want 1000",
               {done, cpu_rst, ready, err});
    end
    checks++;
    if (n_wr - w0 != 3 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL b2b_count got %0d writes want 3", n_wr - w0);
    end else begin
      checks++;
      if (wr_cyc[c0+1] != wr_cyc[c0] + 1 || wr_cyc[c0+2] != wr_cyc[c0] + 2) begin
        errors++;
        $display("FAIL b2b_rate got cycles %0d %0d %0d want consecutive",
                 wr_cyc[c0], wr_cyc[c0+1], wr_cyc[c0+2]);
      end
    end
  endtask

  task automatic test_bad_checksum();
    int w0;
    do_start();
    prog = '{8'h03, 8'h21, 8'h42, 8'h84, 8'h00};
    w0 = n_wr;
    run_stream(1'b0, 0);
    checks++;
    if ({err, cpu_rst, done, ready} !== 4'b1100 || n_wr - w0 != 3) begin
      errors++;
      $display("FAIL bad_csum got err/cpu/done/rdy=%b writes=%0d want 1100 3",
               {err, cpu_rst, done, ready}, n_wr - w0);
    end
    do_start();
    checks++;
    if (err !== 1'b0) begin
      errors++;
      $display("FAIL err_clear got %b want 0", err);
    end
  endtask

  task automatic test_bad_length();
    int w0;
    int n;
    w0 = n_wr;
    send(8'h00);
    valid = 1'b0;
    @(posedge clk);
    #1;
    checks++;
    if ({err, ready, cpu_rst} !== 3'b101 || n_wr != w0) begin
      errors++;
      $display("FAIL len_zero got err/rdy/cpu=%b writes=%0d want 101 0",
               {err, ready, cpu_rst}, n_wr - w0);
    end
    for (int k = 0; k < 2; k++) begin
      start4 = 1'b1;
      @(posedge clk);
      #1;
      start4 = 1'b0;
      valid4 = 1'b1;
      data4  = (k == 0) ? 8'h05 : 8'h04;
      n = 0;
      @(negedge clk);
      while (!ready4 && n < 20) begin
        @(negedge clk);
        n++;
      end
      @(posedge clk);
      #1;
      valid4 = 1'b0;
      checks++;
      if (k == 0 && ({err4, ready4, we4} !== 3'b100)) begin
        errors++;
        $display("FAIL len_over got err/rdy/we=%b want 100",
                 {err4, ready4, we4});
      end
      if (k == 1 && ({err4, ready4} !== 2'b01)) begin
        errors++;
        $display("FAIL len_max got err/rdy=%b want 01", {err4, ready4});
      end
    end
  endtask

  task automatic test_gaps_start();
    int w0;
    do_start();
    prog = '{8'h04, 8'h11, 8'h22, 8'h33, 8'h44, 8'h44};
    w0 = n_wr;
    run_stream(1'b1, 2);
    checks++;
    if ({done, cpu_rst, err} !== 3'b100 || n_wr - w0 != 4 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL gaps got done/cpu/err=%b writes=%0d want 100 4",
               {done, cpu_rst, err}, n_wr - w0);
    end
  endtask

  task automatic test_reset_midload();
    int w0;
    do_start();
    send(8'h03);
    exp_q.push_back({8'h00, 8'h21});
    send(8'h21);
    exp_q.push_back({8'h01, 8'h42});
    send(8'h42);
    valid = 1'b0;
    rst   = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    w0  = n_wr;
    checks++;
    if ({we, ready, cpu_rst, done} !== 4'b0010) begin
      errors++;
      $display("FAIL mid_reset got we/rdy/cpu/done=%b want 0010",
               {we, ready, cpu_rst, done});
    end
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (n_wr != w0 || exp_q.size() != 0 || ready !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset_idle got writes=%0d pending=%0d rdy=%b want 0 0 0",
               n_wr - w0, exp_q.size(), ready);
    end
    do_start();
    prog = '{8'h03, 8'h21, 8'h42, 8'h84, 8'hE7};
    run_stream(1'b0, 0);
    checks++;
    if ({done, cpu_rst} !== 2'b10 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL reload got done/cpu=%b want 10", {done, cpu_rst});
    end
  endtask

  initial begin
    rst    = 1'b1;
    start  = 1'b0;
    valid  = 1'b0;
    data   = 8'h00;
    start4 = 1'b0;
    valid4 = 1'b0;
    data4  = 8'h00;
    #1;
    test_reset();
    test_back_to_back();
    test_bad_checksum();
    test_bad_length();
    test_gaps_start();
    test_reset_midload();
    repeat (2) @(posedge clk);
    #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/program_loader_unit.md
# program_loader_unit

Boot-time loader that receives a program as a byte stream over a valid/ready handshake and writes it into a writable instruction memory, one instruction byte per address starting at 0. It holds the processor core in reset while loading and verifies an XOR checksum before release. It sits between the external host/bench and the write port of the instruction memory. It is the writer counterpart of the PC-driven instruction fetch path.

## Interface
- MEM_DEPTH, 256: number of instruction memory locations; valid program lengths are 1..MEM_DEPTH (never above 255 since length is one byte).
- clock  input  1  rising-edge clock for all state.
- reset  input  1  synchronous, active-high; one clock, reset is synchronous and active-high.
- Start  input  1  begins a load; sampled in IDLE, RUN and ERROR only.
- InValid  input  1  host has a byte on InData.
- InData  input  8  stream byte: length, then instructions, then checksum.
- InReady  output  1  loader accepts a byte this cycle (registered).
- IMWriteEnable  output  1  one-cycle write strobe to instruction memory.
- IMWriteAddress  output  8  instruction memory write address.
- IMWriteData  output  8  instruction byte to write.
- CPUReset  output  1  holds processor core in reset while high.
- Done  output  1  program loaded and verified; core running.
- Error  output  1  bad length or checksum mismatch.

## Operation
- Transfer occurs at a rising edge where InValid && InReady. Host may hold InValid high or insert gaps; the loader never drops or duplicates a byte.
- Stream format: byte 0 = length L, then L instruction bytes, then one checksum byte = XOR of the L instruction bytes.
- States: IDLE, LEN, LOAD, CHECK, RUN, ERROR.
- IDLE: InReady=0, CPUReset=1. On Start go to LEN.
- LEN: InReady=1. On transfer:
  - L==0 or L>MEM_DEPTH -> ERROR.
  - Otherwise latch L, clear index and checksum accumulator, go to LOAD.
- LOAD: InReady=1. Each transfer:
  - Registers IMWriteAddress=index and IMWriteData=InData, and pulses IMWriteEnable.
  - Updates checksum ^= InData and increments index.
  - The L-th transfer goes to CHECK.
- CHECK: InReady=1. On transfer, byte == accumulator -> RUN; otherwise -> ERROR.
- RUN: Done=1, CPUReset=0, InReady=0. Start returns to LEN with CPUReset=1 and Done=0.
- ERROR: Error=1, CPUReset=1, InReady=0. Start returns to LEN and clears Error.
- Start is ignored in LEN, LOAD and CHECK.
- Index arithmetic is 8-bit. No wrap is possible because L≤MEM_DEPTH is enforced before LOAD.
- Memory contents are never cleared by the loader.

## Timing
- All outputs are registered.
- Reset values: InReady=0, IMWriteEnable=0, IMWriteAddress=0, IMWriteData=0, CPUReset=1, Done=0, Error=0. State=IDLE, index=0, accumulator=0.
- Start sampled at edge N -> InReady=1 from edge N+1.
- LOAD transfer at edge N -> IMWriteEnable=1 with address/data valid during cycle N+1 only.
- Back-to-back transfers give back-to-back write strobes at full rate (1 byte/clock).
- InReady drops at the same edge that accepts the checksum byte or the rejected length byte. No extra byte is accepted.
- Checksum accepted at edge N -> Done=1 and CPUReset=0, or Error=1, from edge N+1.
- Reset asserted mid-load:
  - Next edge returns to IDLE with all reset values; no further writes occur.
  - A strobe already registered is cancelled (IMWriteEnable=0).
- Reset and Start high at the same edge: reset wins.

## Test plan
- Apply reset for 2 cycles -> InReady=0, IMWriteEnable=0, CPUReset=1, Done=0, Error=0, IMWriteAddress=0.
- Start, then stream 0x03, 0x21, 0x42, 0x84, 0xE7 back-to-back:
  - Writes (0,0x21), (1,0x42), (2,0x84) on three consecutive cycles.
  - Cycle after the checksum: Done=1, CPUReset=0, InReady=0.
- Same program with checksum 0x00 -> three writes occur, then Error=1, CPUReset=1, Done=0. Start afterward clears Error and InReady=1 next cycle.
- Length byte 0x00 -> Error=1 with no write strobes. With MEM_DEPTH=4, length 0x05 -> Error=1.
- Stream L=4 (0x11, 0x22, 0x33, 0x44, checksum 0x44) with InValid toggled every other cycle and a Start pulse mid-LOAD:
  - Addresses 0..3 in order; Start has no effect.
  - Done=1 after the checksum.
- Assert reset after 2 of 3 instruction bytes:
  - No further strobes, state IDLE, CPUReset=1.
  - A fresh full load then succeeds with Done=1.
